// File: rtl/oscope_frame_reader_if.sv
// Sample stream from the oscilloscope frame reader to the display pipeline.
// Each beat carries the sample, its x index and an end-of-frame flag.
interface oscope_frame_reader_if #(
   parameter int XW = 10
);
   logic signed [7:0] data;
   logic [XW-1:0]     x;
   logic              last;
   logic              valid;
   logic              ready;

   modport master (output data, x, last, valid, input ready);
   modport slave  (input data, x, last, valid, output ready);
endinterface

// File: rtl/oscope_frame_reader.sv
// Oscilloscope readout sequencer: arms the capture block, drains one frame
// into a valid/ready stream, and reports per-frame extrema and trigger status.
module oscope_frame_reader #(
   parameter int DLEN    = 1000,
   parameter int XW      = 10,
   parameter int HOLDOFF = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arm_i,
   input  logic              auto_en_i,
   input  logic              abort_i,
   output logic              cap_start_o,
   input  logic              cap_busy_i,
   input  logic              cap_trig_i,
   output logic              cap_read_o,
   input  logic signed [7:0] cap_data_i,
   oscope_frame_reader_if.master m,
   output logic              frame_done_o,
   output logic              frame_trig_o,
   output logic signed [7:0] frame_min_o,
   output logic signed [7:0] frame_max_o,
   output logic              active_o
);

   localparam int CW = XW + 1;
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
   localparam logic [CW-1:0] DLEN_C = CW'(DLEN);
   localparam logic [CW-1:0] LAST_C = CW'(DLEN - 1);
   localparam logic [HW-1:0] HOLD_C = HW'(HOLDOFF);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_WAIT, S_DRAIN, S_DONE
   } state_t;

   state_t            state_q;
   logic              guard_q;
   logic [CW-1:0]     rd_cnt_q;
   logic [HW-1:0]     hold_q;
   logic              cap_start_q;
   logic              frame_done_q;
   logic              frame_trig_q;
   logic signed [7:0] frame_min_q;
   logic signed [7:0] frame_max_q;
   logic signed [7:0] run_min_q;
   logic signed [7:0] run_max_q;
   logic signed [7:0] m_data_q;
   logic [XW-1:0]     m_x_q;
   logic              m_last_q;
   logic              m_valid_q;
   logic              rd_req;
   logic              auto_fire;

   // Read only while the one-entry output register is free or draining this cycle.
   assign rd_req = !rst && !abort_i && (state_q == S_DRAIN) && (rd_cnt_q < DLEN_C)
                   && (!m_valid_q || m.ready);

   // The counter reaches zero on this IDLE cycle, so HOLDOFF idle cycles precede START.
   assign auto_fire = auto_en_i && (hold_q <= HW'(1));

   assign cap_start_o  = cap_start_q;
   assign cap_read_o   = rd_req;
   assign frame_done_o = frame_done_q;
   assign frame_trig_o = frame_trig_q;
   assign frame_min_o  = frame_min_q;
   assign frame_max_o  = frame_max_q;
   assign active_o     = (state_q != S_IDLE);
   assign m.data       = m_data_q;
   assign m.x          = m_x_q;
   assign m.last       = m_last_q;
   assign m.valid      = m_valid_q;

   // Frame sequencer, output stream register and running extrema.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         guard_q      <= 1'b0;
         rd_cnt_q     <= {CW{1'b0}};
         hold_q       <= {HW{1'b0}};
         cap_start_q  <= 1'b0;
         frame_done_q <= 1'b0;
         frame_trig_q <= 1'b0;
         frame_min_q  <= 8'sd0;
         frame_max_q  <= 8'sd0;
         run_min_q    <= 8'sd0;
         run_max_q    <= 8'sd0;
         m_data_q     <= 8'sd0;
         m_x_q        <= {XW{1'b0}};
         m_last_q     <= 1'b0;
         m_valid_q    <= 1'b0;
      end else begin
         cap_start_q  <= 1'b0;
         frame_done_q <= 1'b0;

         if (abort_i) begin
            m_valid_q <= 1'b0;
         end else if (rd_req) begin
            m_data_q  <= cap_data_i;
            m_x_q     <= rd_cnt_q[XW-1:0];
            m_last_q  <= (rd_cnt_q == LAST_C);
            m_valid_q <= 1'b1;
            rd_cnt_q  <= rd_cnt_q + CW'(1);
            if ((rd_cnt_q == {CW{1'b0}}) || (cap_data_i < run_min_q)) begin
               run_min_q <= cap_data_i;
            end
            if ((rd_cnt_q == {CW{1'b0}}) || (cap_data_i > run_max_q)) begin
               run_max_q <= cap_data_i;
            end
         end else if (m_valid_q && m.ready) begin
            m_valid_q <= 1'b0;
         end

         if (abort_i) begin
            state_q  <= S_IDLE;
            rd_cnt_q <= {CW{1'b0}};
            hold_q   <= HOLD_C;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (arm_i || auto_fire) begin
                     state_q     <= S_START;
                     cap_start_q <= 1'b1;
                  end else if (hold_q != {HW{1'b0}}) begin
                     hold_q <= hold_q - HW'(1);
                  end
               end
               S_START: begin
                  state_q <= S_WAIT;
                  guard_q <= 1'b1;
               end
               S_WAIT: begin
                  // The first WAIT cycle ignores cap_busy: the capture block may not have raised it yet.
                  if (guard_q) begin
                     guard_q <= 1'b0;
                  end else if (!cap_busy_i) begin
                     state_q      <= S_DRAIN;
                     frame_trig_q <= cap_trig_i;
                     rd_cnt_q     <= {CW{1'b0}};
                  end
               end
               S_DRAIN: begin
                  if ((rd_cnt_q == DLEN_C) && m_valid_q && m.ready) begin
                     state_q      <= S_DONE;
                     frame_done_q <= 1'b1;
                     frame_min_q  <= run_min_q;
                     frame_max_q  <= run_max_q;
                  end
               end
               S_DONE: begin
                  state_q  <= S_IDLE;
                  hold_q   <= HOLD_C;
                  rd_cnt_q <= {CW{1'b0}};
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
